// File: rtl/fir_pkg.sv
// Shared filter-library package.
// Holds the FIR control state encoding and the signed saturation helper
// used by the saturating adders and MAC datapaths.
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  // Clamp v to the signed range of a w-bit value. Callers narrow the 32-bit
  // result back to w bits with a size cast.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                             input int                 w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_decim_mac.sv
// One step of the time-multiplexed multiply / saturating accumulate.
// Ports:
//   d        - selected delay-line sample (signed)
//   c        - selected coefficient, Q1.(TAP_COEFF_WIDTH-1) (signed)
//   acc      - current accumulator value
//   acc_next - sat(acc + sat((d*c) >>> (TAP_COEFF_WIDTH-1)))
module fir_decim_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5
) (
  input  logic signed [DATA_WIDTH-1:0]      d,
  input  logic signed [TAP_COEFF_WIDTH-1:0] c,
  input  logic signed [DATA_WIDTH-1:0]      acc,
  output logic signed [DATA_WIDTH-1:0]      acc_next
);

  localparam int PW = DATA_WIDTH + TAP_COEFF_WIDTH;

  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] term;
  logic signed [DATA_WIDTH:0]   sum;

  // Full-precision product, then drop the coefficient fraction bits
  // (arithmetic shift rounds toward minus infinity).
  assign prod     = PW'(d) * PW'(c);
  assign shifted  = prod >>> (TAP_COEFF_WIDTH - 1);
  assign term     = DATA_WIDTH'(sat(32'(shifted), DATA_WIDTH));
  // One guard bit is enough for the sum of two DATA_WIDTH values.
  assign sum      = (DATA_WIDTH + 1)'(acc) + (DATA_WIDTH + 1)'(term);
  assign acc_next = DATA_WIDTH'(sat(32'(sum), DATA_WIDTH));

endmodule

// File: rtl/fir_decim.sv
// Decimating FIR with a single shared multiply/saturating-accumulate.
// Accepts samples while IDLE; every DECIM-th accepted sample latches the
// coefficients and runs NUM_TAPS MAC cycles (tap 0 first), then emits one
// output with a one-cycle out_valid pulse.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in, in_valid         - input sample and its valid
//   in_ready             - high while IDLE (sample accepted on in_valid&&in_ready)
//   tap_coeffs[k]        - coefficient multiplying x[n-k]
//   out, out_valid       - decimated output and its update pulse
module fir_decim
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 50,
  parameter int DECIM           = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic signed [DATA_WIDTH-1:0]              in,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0]  tap_coeffs,
  output logic signed [DATA_WIDTH-1:0]              out,
  output logic                                      out_valid
);

  localparam int KW  = $clog2(NUM_TAPS);
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t                                   state, state_n;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]      dly;
  logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0] coef;
  logic [KW-1:0]                            k;
  logic [PHW-1:0]                           phase;
  logic signed [DATA_WIDTH-1:0]             acc, acc_next;
  logic                                     accept, start, last;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign start    = accept && (phase == PHW'(DECIM - 1));
  assign last     = (state == MAC) && (k == KW'(NUM_TAPS - 1));

  fir_decim_mac #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TAP_COEFF_WIDTH(TAP_COEFF_WIDTH)
  ) u_mac (
    .d       ($signed(dly[k])),
    .c       ($signed(coef[k])),
    .acc     (acc),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = MAC;
      MAC:     if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly       <= '0;
      coef      <= '0;
      k         <= '0;
      phase     <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        dly   <= {dly[NUM_TAPS-2:0], in};
        phase <= (phase == PHW'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
      if (start) begin
        k    <= '0;
        acc  <= '0;
        coef <= tap_coeffs;
      end
      // No accept can coincide with MAC (in_ready is low), so the delay
      // line and coefficient latch are frozen for the whole computation.
      if (state == MAC) begin
        acc <= acc_next;
        k   <= k + 1'b1;
        if (last) begin
          out       <= acc_next;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
module tb_fir_decim;

  localparam int DW = 5;
  localparam int CW = 5;
  localparam int NT = 4;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: NUM_TAPS=4, DECIM=2
  logic signed [DW-1:0]      din;
  logic                      in_valid;
  logic                      in_ready;
  logic [NT-1:0][CW-1:0]     coeffs;
  logic signed [DW-1:0]      out;
  logic                      out_valid;

  // second DUT: NUM_TAPS=2, DECIM=1
  logic signed [DW-1:0]      din1;
  logic                      v1;
  logic                      rdy1;
  logic [1:0][CW-1:0]        coeffs1;
  logic signed [DW-1:0]      out1;
  logic                      ov1;

  fir_decim #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(NT), .DECIM(DC)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .tap_coeffs(coeffs), .out(out), .out_valid(out_valid)
  );

  fir_decim #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(2), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(din1), .in_valid(v1), .in_ready(rdy1),
    .tap_coeffs(coeffs1), .out(out1), .out_valid(ov1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int cyc; } exp_t;
  exp_t sb[$];
  int   got_q[$];
  int   md[NT];
  int   mph = 0;

  task automatic chk(input string tag, input int got, input int expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, expv);
    end
  endtask

  function automatic int clampd(input int v);
    if (v > 15) return 15;
    if (v < -16) return -16;
    return v;
  endfunction

  function automatic int cval(input int k);
    logic signed [CW-1:0] c;
    c = coeffs[k];
    return int'(c);
  endfunction

  // Golden model of the accept edge; c0 is the cycle count just before it.
  task automatic model_accept(input int x, input int c0);
    int acc, t;
    for (int k = NT - 1; k > 0; k--) md[k] = md[k-1];
    md[0] = x;
    if (mph == DC - 1) begin
      acc = 0;
      for (int k = 0; k < NT; k++) begin
        t   = clampd((md[k] * cval(k)) >>> (CW - 1));
        acc = clampd(acc + t);
      end
      sb.push_back('{val: acc, cyc: c0 + NT + 1});
      mph = 0;
    end else begin
      mph++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) md[k] = 0;
    mph = 0;
    sb.delete();
  endtask

  task automatic set_coeffs(input int a, input int b, input int c, input int d);
    coeffs[0] = CW'(a); coeffs[1] = CW'(b); coeffs[2] = CW'(c); coeffs[3] = CW'(d);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int x);
    int  n;
    int  c0;
    bit  rdy;
    n = 0;
    din = DW'(x);
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      c0  = cyc;
      @(posedge clk);
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    if (rdy) model_accept(x, c0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Output monitor / scoreboard consumer
  int lowrun = 0;
  int prev_ov = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      lowrun  = 0;
      prev_ov = 0;
    end else begin
      if (out_valid) begin
        chk("pulse_single", prev_ov, 0);
        chk("ready_with_valid", int'(in_ready), 1);
        got_q.push_back(int'(out));
        if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("out", int'(out), e.val);
          chk("out_cycle", cyc, e.cyc);
        end
      end
      if (!in_ready) lowrun++;
      else begin
        if (lowrun != 0) chk("ready_low_len", lowrun, NT);
        lowrun = 0;
      end
      prev_ov = int'(out_valid);
    end
  end

  task automatic send1(input int x, input int new_c);
    int n;
    int c0;
    bit rdy;
    n = 0;
    din1 = DW'(x);
    v1 = 1'b1;
    forever begin
      rdy = rdy1;
      c0  = cyc;
      @(posedge clk);
      @(negedge clk);
      if (rdy || n > 50) break;
      n++;
    end
    v1 = 1'b0;
    // coefficient change while the MAC runs must not matter
    coeffs1[0] = CW'(new_c);
    coeffs1[1] = CW'(new_c);
    n = 0;
    while (!ov1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dut1_valid", int'(ov1), 1);
    chk("dut1_cycle", cyc, c0 + 3);
  endtask

  initial begin
    int last;
    din = '0; in_valid = 1'b0; coeffs = '0;
    din1 = '0; v1 = 1'b0; coeffs1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst1_out", int'(out1), 0);
    chk("rst1_in_ready", int'(rdy1), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic
    set_coeffs(8, 8, 8, 8);
    got_q.delete();
    send(2); send(4); send(6); send(8);
    drain();
    chk("basic_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("basic_out0", got_q[0], 3);
      chk("basic_out1", got_q[1], 10);
    end

    // 2: positive saturation
    set_coeffs(15, 15, 15, 15);
    for (int i = 0; i < 8; i++) send(15);
    drain();
    last = got_q[$];
    chk("pos_sat_last", last, 15);

    // 3: negative saturation
    for (int i = 0; i < 8; i++) send(-16);
    drain();
    last = got_q[$];
    chk("neg_sat_last", last, -16);

    // 4: continuous in_valid, mixed coefficients and data
    set_coeffs(3, -7, 12, -2);
    for (int i = 0; i < 12; i++) send(int'($urandom_range(0, 31)) - 16);
    drain();

    // 5: reset in the middle of a MAC
    send(9); send(-5);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_out", int'(out), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_no_valid", int'(out_valid), 0);
    got_q.delete();
    send(5); send(7);
    drain();
    // fresh start: d = {7,5,0,0}; 7*3>>>4 = 1, 5*-7>>>4 = -3 -> -2
    chk("after_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("after_rst_out", got_q[0], -2);

    // 6: DECIM=1, NUM_TAPS=2
    coeffs1[0] = CW'(8);
    coeffs1[1] = CW'(8);
    send1(4, 0);
    chk("dut1_out0", int'(out1), 2);
    coeffs1[0] = CW'(8);
    coeffs1[1] = CW'(8);
    send1(4, -16);
    chk("dut1_out1", int'(out1), 4);
    @(negedge clk);
    chk("dut1_pulse_end", int'(ov1), 0);
    chk("dut1_out_hold", int'(out1), 4);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
